// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial controller for the RAM port shared by instruction fetch and the MEM stage.
// MEM has fixed priority. Multi-byte accesses are split little-endian and reassembled into words.
module mem_arbiter_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic                r_owner_mem;
    logic [2:0]          r_n;
    logic [2:0]          r_cnt;
    logic [31:0]         r_asm;
    logic                r_if_done;
    logic                r_mem_done;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_mem_rdata;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [7:0]          r_ram_dout;
    logic                r_ram_wr;

    logic [2:0]          w_mem_n;
    logic [1:0]          w_byte_out;
    logic [1:0]          w_byte_in;
    logic [31:0]         w_asm_next;
    logic                w_unused;

    // Address bits above the RAM width are intentionally dropped.
    assign w_unused   = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};
    assign w_byte_out = r_cnt[1:0];
    // The byte on ram_din belongs to the address driven two edges before the capture edge.
    assign w_byte_in  = 2'(r_cnt - 3'd2);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_mem_n = 3'd4;
        case (mem_size)
            2'b00:   w_mem_n = 3'd1;
            2'b01:   w_mem_n = 3'd2;
            default: w_mem_n = 3'd4;
        endcase
    end

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{w_byte_in, 3'b000} +: 8] = ram_din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_owner_mem <= 1'b0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_ram_addr  <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req) begin
                        r_addr      <= mem_addr[ADDR_W-1:0];
                        r_we        <= mem_we;
                        r_wdata     <= mem_wdata;
                        r_owner_mem <= 1'b1;
                        r_n         <= w_mem_n;
                        r_cnt       <= 3'd1;
                        r_asm       <= '0;
                        r_ram_addr  <= mem_addr[ADDR_W-1:0];
                        r_ram_wr    <= mem_we;
                        r_ram_dout  <= mem_wdata[7:0];
                        r_state     <= S_XFER;
                    end else if (if_req) begin
                        r_addr      <= if_addr[ADDR_W-1:0];
                        r_we        <= 1'b0;
                        r_wdata     <= '0;
                        r_owner_mem <= 1'b0;
                        r_n         <= 3'd4;
                        r_cnt       <= 3'd1;
                        r_asm       <= '0;
                        r_ram_addr  <= if_addr[ADDR_W-1:0];
                        r_ram_wr    <= 1'b0;
                        r_ram_dout  <= '0;
                        r_state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (r_cnt < r_n) begin
                        r_ram_addr <= r_addr + ADDR_W'(r_cnt);
                        r_ram_dout <= r_wdata[{w_byte_out, 3'b000} +: 8];
                        r_ram_wr   <= r_we;
                    end else begin
                        r_ram_addr <= '0;
                        r_ram_dout <= '0;
                        r_ram_wr   <= 1'b0;
                    end
                    if (r_cnt >= 3'd2) begin
                        r_asm <= w_asm_next;
                    end
                    if (r_cnt == r_n + 3'd1) begin
                        if (r_owner_mem) begin
                            r_mem_done <= 1'b1;
                            if (!r_we) begin
                                r_mem_rdata <= w_asm_next;
                            end
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= w_asm_next;
                        end
                        r_state <= S_DONE;
                    end
                    r_cnt <= r_cnt + 3'd1;
                end
                S_DONE: begin
                    r_if_done  <= 1'b0;
                    r_mem_done <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_done   = r_if_done;
    assign if_rdata  = r_if_rdata;
    assign mem_done  = r_mem_done;
    assign mem_rdata = r_mem_rdata;
    assign busy      = (r_state != S_IDLE);
    assign ram_addr  = r_ram_addr;
    assign ram_dout  = r_ram_dout;
    assign ram_wr    = r_ram_wr;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: a byte-array model predicts writes, done timing and read data.
module tb_mem_arbiter_ctrl;
    localparam int ADDR_W = 17;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        bit          is_mem;
        bit          is_read;
        logic [31:0] rdata;
        int          done_cyc;
    } done_exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        int                cyc;
    } wr_exp_t;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              if_req    = 1'b0;
    logic [31:0]       if_addr   = '0;
    logic              mem_req   = 1'b0;
    logic              mem_we    = 1'b0;
    logic [1:0]        mem_size  = '0;
    logic [31:0]       mem_addr  = '0;
    logic [31:0]       mem_wdata = '0;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;

    logic [7:0]  ram    [DEPTH];
    logic [7:0]  shadow [DEPTH];
    bit          exp_busy [65536];
    done_exp_t   done_q [$];
    wr_exp_t     wr_q [$];
    int          cyc       = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          next_free = 0;
    bit          mon_en    = 1'b0;
    logic [31:0] last_if   = '0;

    mem_arbiter_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ram_din <= ram[ram_addr];
        if (ram_wr) ram[ram_addr] = ram_dout;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_byte(input int a, input logic [7:0] v);
        ram[a]    = v;
        shadow[a] = v;
    endtask

    // Reference model: accept at edge e0, N byte steps, done on edge e0+N+1; returns next possible accept edge.
    function automatic int predict(input bit is_mem, input bit we, input logic [1:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata, input int e0);
        int                n;
        done_exp_t         d;
        wr_exp_t           w;
        logic [ADDR_W-1:0] a;
        n = !is_mem ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        d.is_mem   = is_mem;
        d.is_read  = !we;
        d.rdata    = '0;
        d.done_cyc = e0 + n + 1;
        for (int j = 0; j < n; j++) begin
            a = addr[ADDR_W-1:0] + ADDR_W'(j);
            if (we) begin
                shadow[a] = wdata[8*j +: 8];
                w.addr = a;
                w.data = wdata[8*j +: 8];
                w.cyc  = e0 + j;
                wr_q.push_back(w);
            end else begin
                d.rdata[8*j +: 8] = shadow[a];
            end
        end
        done_q.push_back(d);
        for (int c = e0; c <= e0 + n + 1; c++) exp_busy[c] = 1'b1;
        return e0 + n + 3;
    endfunction

    // Raise the chosen requests when the model says the port is idle, then drop each once accepted.
    task automatic go(input bit want_if, input bit want_mem, input bit we, input logic [1:0] size,
                      input logic [31:0] maddr, input logic [31:0] wdata, input logic [31:0] iaddr,
                      input int if_reps);
        int e;
        int last_if_accept;
        while (cyc + 1 < next_free) @(negedge clk);
        mem_req   = want_mem;
        mem_we    = we;
        mem_size  = size;
        mem_addr  = maddr;
        mem_wdata = wdata;
        if_req    = want_if;
        if_addr   = iaddr;
        e = cyc + 1;
        if (want_mem) e = predict(1'b1, we, size, maddr, wdata, e);
        last_if_accept = e;
        if (want_if) begin
            for (int r = 0; r < if_reps; r++) begin
                last_if_accept = e;
                e = predict(1'b0, 1'b0, 2'b10, iaddr, 32'h0, e);
            end
        end
        next_free = e;
        @(negedge clk);
        mem_req   = 1'b0;
        mem_we    = 1'($urandom_range(0, 1));
        mem_size  = 2'($urandom_range(0, 3));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        if (want_if) begin
            while (cyc < last_if_accept) @(negedge clk);
            if_req  = 1'b0;
            if_addr = $urandom;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_done"},   32'(if_done),   32'd0);
        check({tag, "_mem_done"},  32'(mem_done),  32'd0);
        check({tag, "_if_rdata"},  if_rdata,       32'd0);
        check({tag, "_mem_rdata"}, mem_rdata,      32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
        check({tag, "_ram_dout"},  32'(ram_dout),  32'd0);
        check({tag, "_ram_wr"},    32'(ram_wr),    32'd0);
    endtask

    task automatic drain();
        while (cyc < next_free + 2) @(negedge clk);
        check("done_queue_empty",  32'(done_q.size()), 32'd0);
        check("write_queue_empty", 32'(wr_q.size()),   32'd0);
    endtask

    // Monitor: compares every RAM write and every done pulse against the queued expectations.
    initial begin
        done_exp_t d;
        wr_exp_t   w;
        forever begin
            @(negedge clk);
            if (!rst) last_if = '0;
            if (mon_en) begin
                check("busy", 32'(busy), 32'(exp_busy[cyc]));
                if (ram_wr) begin
                    if (wr_q.size() == 0) begin
                        check("spurious_write", 32'(ram_wr), 32'd0);
                    end else begin
                        w = wr_q.pop_front();
                        check("write_addr", 32'(ram_addr), 32'(w.addr));
                        check("write_data", 32'(ram_dout), 32'(w.data));
                        check("write_cycle", cyc, w.cyc);
                    end
                end
                if (if_done || mem_done) begin
                    check("dual_done", 32'(if_done & mem_done), 32'd0);
                    if (done_q.size() == 0) begin
                        check("spurious_done", 32'({if_done, mem_done}), 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_owner", 32'(mem_done), 32'(d.is_mem));
                        check("done_cycle", cyc, d.done_cyc);
                        if (d.is_mem) begin
                            check("if_rdata_hold", if_rdata, last_if);
                            if (d.is_read) check("mem_rdata", mem_rdata, d.rdata);
                        end else begin
                            check("if_rdata", if_rdata, d.rdata);
                            last_if = d.rdata;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = 8'($urandom);
            shadow[i] = ram[i];
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst       = 1'b1;
        mon_en    = 1'b1;
        next_free = cyc + 1;

        set_byte(32'h100, 8'h13);
        set_byte(32'h101, 8'h00);
        set_byte(32'h102, 8'h00);
        set_byte(32'h103, 8'h00);
        go(1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0000_0100, 1);
        go(1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0020, 32'hAABB_CCDD, 32'h0, 1);
        set_byte(32'h40, 8'h34);
        set_byte(32'h41, 8'h12);
        go(1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0040, $urandom, 32'h0000_0200, 1);
        go(1'b0, 1'b1, 1'b1, 2'b10, 32'h0001_FFFE, 32'h1122_3344, 32'h0, 1);
        go(1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0001_FFFD, 3);
        drain();
        check("wrap_store_0x1FFFE", 32'(ram[17'h1FFFE]), 32'h44);
        check("wrap_store_0x00001", 32'(ram[17'h00001]), 32'h11);

        for (int t = 0; t < 40; t++) begin
            int          kind;
            logic [31:0] ma;
            kind = $urandom_range(0, 2);
            ma   = $urandom;
            if ($urandom_range(0, 3) == 0) ma[16:0] = 17'h1FFFC + 17'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            go(kind != 1, kind != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ma, $urandom, $urandom, $urandom_range(1, 2));
        end
        drain();

        // Abort an IF read after two transfer edges; the access must vanish without a done.
        mon_en  = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        @(negedge clk);
        if_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        mon_en    = 1'b1;
        next_free = cyc + 1;
        go(1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0000_0300, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
